// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder built around a single 4-bit carry-lookahead
//   slice. One nibble is added per clock, least significant first, with the
//   inter-nibble carry held in a register.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     in_valid   operands and carry_in are valid
//     in_ready   block can accept a new operation (IDLE)
//     left       first operand  [WIDTH-1:0]
//     right      second operand [WIDTH-1:0]
//     carry_in   carry into bit 0
//     out_valid  result registers hold a completed result (DONE)
//     out_ready  consumer accepts the result
//     sum        registered result [WIDTH-1:0]
//     carry_out  unsigned carry out of bit WIDTH-1
//     overflow   two's-complement signed overflow
//     busy       addition in progress (ADD)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for an operation; result registers hold last result
//   ADD   | one nibble per clock through the CLA slice, NIBBLES cycles
//   DONE  | result valid, held until out_ready

module carry_lookahead_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = carry_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign sum       = p ^ c[3:0];
  assign carry_out = c[4];

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] l_q;
  logic [WIDTH-1:0] r_q;
  logic             c_q;
  logic             sign_l_q;
  logic             sign_r_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic [3:0]       cla_sum;
  logic             cla_co;
  logic             last_nibble;
  logic [WIDTH-1:0] sum_shift;

  carry_lookahead_adder_4bit u_cla (
    .a         (l_q[3:0]),
    .b         (r_q[3:0]),
    .carry_in  (c_q),
    .sum       (cla_sum),
    .carry_out (cla_co)
  );

  assign last_nibble = (cnt_q == CW'(NIBBLES - 1));

  // Slice result enters at the top; after NIBBLES shifts the first
  // nibble computed sits at bit 0. Written this way so WIDTH=4 needs no
  // special case.
  always_comb begin
    sum_shift = sum_q >> 4;
    sum_shift[WIDTH-1 -: 4] = cla_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ADD;
      end
      ADD: begin
        busy = 1'b1;
        if (last_nibble) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      l_q         <= '0;
      r_q         <= '0;
      c_q         <= 1'b0;
      sign_l_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            l_q      <= left;
            r_q      <= right;
            c_q      <= carry_in;
            sign_l_q <= left[WIDTH-1];
            sign_r_q <= right[WIDTH-1];
            cnt_q    <= '0;
          end
        end
        ADD: begin
          sum_q <= sum_shift;
          c_q   <= cla_co;
          l_q   <= l_q >> 4;
          r_q   <= r_q >> 4;
          if (last_nibble) begin
            // cla_sum[3] is the final sum MSB on the last nibble.
            cnt_q       <= '0;
            carry_out_q <= cla_co;
            overflow_q  <= (sign_l_q == sign_r_q) && (cla_sum[3] != sign_l_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;
  logic         busy;

  logic         in_valid4 = 1'b0;
  logic         in_ready4;
  logic [3:0]   left4 = '0;
  logic [3:0]   right4 = '0;
  logic         cin4 = 1'b0;
  logic         out_valid4;
  logic         out_ready4 = 1'b0;
  logic [3:0]   sum4;
  logic         carry_out4;
  logic         overflow4;
  logic         busy4;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
    .left(left), .right(right), .carry_in(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .busy(busy)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .left(left4), .right(right4), .carry_in(cin4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sum(sum4), .carry_out(carry_out4),
    .overflow(overflow4), .busy(busy4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted operation produces its arithmetic
  // result NIB cycles later and stays published until out_ready.
  bit           m_idle = 1;
  bit           m_done = 0;
  int           m_wait = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_co = 0;
  logic         m_ov = 0;
  logic [W-1:0] p_sum;
  logic         p_co;
  logic         p_ov;
  logic [W:0]   full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle = 1; m_done = 0; m_wait = 0;
      m_sum = '0; m_co = 0; m_ov = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        full  = {1'b0, left} + {1'b0, right} + {{W{1'b0}}, cin};
        p_sum = full[W-1:0];
        p_co  = full[W];
        p_ov  = (left[W-1] == right[W-1]) && (full[W-1] != left[W-1]);
        m_idle = 0;
        m_wait = NIB;
      end
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1;
      if (m_wait == 0) begin
        m_done = 1;
        m_sum = p_sum; m_co = p_co; m_ov = p_ov;
      end
    end else if (m_done && out_ready) begin
      m_done = 0;
      m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", in_ready, m_idle);
      check("out_valid", out_valid, m_done);
      check("busy", busy, m_wait != 0);
      if (m_wait == 0) begin
        check("sum", sum, m_sum);
        check("carry_out", carry_out, m_co);
        check("overflow", overflow, m_ov);
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("wait_in_ready", in_ready, 1);
  endtask

  task automatic do_op(input logic [W-1:0] l, input logic [W-1:0] r, input logic ci,
                       input logic [W-1:0] es, input logic eco, input logic eov,
                       input int hold);
    int lat;
    logic [W-1:0] s0;
    wait_idle();
    @(negedge clk);
    left = l; right = r; cin = ci; in_valid = 1; out_ready = 0;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      left = W'($urandom); right = W'($urandom); cin = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, NIB);
    check("lit_sum", sum, es);
    check("lit_carry_out", carry_out, eco);
    check("lit_overflow", overflow, eov);
    check("model_pin_sum", m_sum, es);
    check("model_pin_co", m_co, eco);
    check("model_pin_ov", m_ov, eov);
    s0 = sum;
    for (int i = 0; i < hold; i++) begin
      left = W'($urandom); right = W'($urandom);
      @(negedge clk);
      check("hold_sum", sum, s0);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 0;
    out_ready = 1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    out_ready = 0;
  endtask

  initial begin
    int k, last, ops, guard;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_carry_out", carry_out, 0);
    check("rst_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    chk_en = 1;

    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 10);

    // reset during the second ADD cycle
    wait_idle();
    @(negedge clk);
    left = 16'hFFFF; right = 16'h0001; cin = 0; in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst = 1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_carry_out", carry_out, 0);
    check("abort_overflow", overflow, 0);
    @(negedge clk);
    rst = 0;
    do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 0);

    // random, in_valid held high: one accept every NIB+2 cycles
    out_ready = 1;
    in_valid = 1;
    ops = 0; k = 0; last = 0; guard = 0;
    while (ops < 2000 && guard < 20000) begin
      @(negedge clk);
      k++; guard++;
      if (in_ready) begin
        if (ops > 0) check("accept_interval", k - last, NIB + 2);
        last = k;
        left = W'($urandom); right = W'($urandom); cin = 1'($urandom);
        ops++;
      end
    end
    check("random_ops_done", ops, 2000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("random_drain", in_ready, 1);
    out_ready = 0;

    // WIDTH=4 instance
    @(negedge clk);
    left4 = 4'hF; right4 = 4'h1; cin4 = 0; in_valid4 = 1;
    check("w4_in_ready", in_ready4, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 0;
    check("w4_busy", busy4, 1);
    @(negedge clk);
    check("w4_out_valid", out_valid4, 1);
    check("w4_sum", sum4, 4'h0);
    check("w4_carry_out", carry_out4, 1);
    check("w4_overflow", overflow4, 0);
    out_ready4 = 1;
    @(negedge clk);
    check("w4_in_ready_after", in_ready4, 1);
    out_ready4 = 0;

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle adder for WIDTH-bit operands. Processes one 4-bit nibble per clock through one instance of carry_lookahead_adder_4bit.
- Sits directly in front of the 4-bit CLA slice: it feeds the slice one nibble per clock, consumes its sum and carry_out, and registers the carry between nibbles.
- Uses valid/ready handshakes on input and output, so a narrow datapath can serve wide additions in the arithmetic samples.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived localparam. Number of ADD cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and carry_in are valid.
- in_ready  output  1  block can accept a new operation.
- left  input  WIDTH  first operand.
- right  input  WIDTH  second operand.
- carry_in  input  1  carry into bit 0.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- carry_out  output  1  unsigned carry out of bit WIDTH-1.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in ADD state.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, nibble counter=0, operand shift registers=0.
  - sum=0, carry_out=0, overflow=0, out_valid=0, busy=0, in_ready=1 once reset deasserts.
- FSM states: IDLE, ADD, DONE.
  - in_ready = (state==IDLE), combinational from state only.
  - busy = (state==ADD).
  - out_valid = (state==DONE).
- IDLE:
  - On in_valid & in_ready: latch left and right into shift registers L and R, latch carry_in into carry register C.
  - Also latch the sign bits left[WIDTH-1] and right[WIDTH-1]. Clear counter, go to ADD.
  - Otherwise stay in IDLE. The sum, carry_out and overflow registers keep their last value.
- ADD (exactly NIBBLES cycles):
  - The CLA slice takes L[3:0], R[3:0] and C.
  - On each edge: the slice sum enters the top nibble of the sum register, which shifts right by 4. C takes the slice carry_out. L and R shift right by 4. Counter increments.
  - When counter==NIBBLES-1, go to DONE on that edge instead of incrementing.
- DONE:
  - carry_out equals C.
  - overflow = (sign_l==sign_r) & (sum[WIDTH-1]!=sign_l).
  - sum, carry_out and overflow hold stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE.
  - in_ready is low in DONE, so there is no same-cycle accept.
- Latency: accept edge at cycle 0, out_valid high from cycle NIBBLES. Minimum throughput is one operation per NIBBLES+2 cycles.
- Arithmetic:
  - {carry_out,sum} = left + right + carry_in, modulo 2^(WIDTH+1).
  - Only the 4-bit slice does addition. No wide adder may be inferred.
- Boundaries:
  - WIDTH=4: one ADD cycle.
  - All-ones + 0 with carry_in=1: carry ripples through every nibble, giving sum=0 and carry_out=1.
  - The counter wraps only through the ADD-to-DONE transition and never exceeds NIBBLES-1.
  - Input changes while not in IDLE are ignored.
  - in_valid held high across DONE is accepted only after the return to IDLE.
  - Reset asserted in ADD or DONE: the in-flight operation is dropped immediately with no partial result visible. out_valid falls asynchronously.

Test Plan:
- WIDTH=16, left=0xFFFF, right=0x0001, carry_in=0 -> after 4 ADD cycles: sum=0x0000, carry_out=1, overflow=0, out_valid high at cycle 4.
- left=0x7FFF, right=0x0001, carry_in=0 -> sum=0x8000, carry_out=0, overflow=1. Also left=0x8000, right=0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- left=0x1234, right=0x4321, carry_in=1 -> sum=0x5556, carry_out=0, overflow=0. Additionally, 2000 random operand sets checked against a reference model, with in_valid held high continuously, expecting one accept every 6 cycles.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> sum, carry_out and overflow stay constant, in_ready stays 0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset pulse during the 2nd ADD cycle of 0xFFFF+0x0001 -> outputs 0 and out_valid=0 asynchronously. A following 0x0003+0x0004 gives sum=0x0007 with no residue from the aborted carry.
- WIDTH=4 build, left=0xF, right=0x1, carry_in=0 -> sum=0x0, carry_out=1, out_valid one cycle after the accept.
